// File: rtl/pad_streamer_pkg.sv
// pad_streamer_pkg: shared default dimensions, widths and FSM state encoding for pad_streamer
package pad_streamer_pkg;
   localparam int DEF_IMG_W = 224;
   localparam int DEF_IMG_H = 224;
   localparam int DEF_PW    = DEF_IMG_W + 2;
   localparam int DEF_PH    = DEF_IMG_H + 2;
   localparam int DEF_DW    = 9;
   localparam int DEF_AW    = 16;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;
endpackage

// File: rtl/pad_streamer_raster.sv
// raster_counter: padded row/column position with wrap, pad and terminal detect
// ports: clk, rst (async, active-high), i_clr (restart at (0,0)), i_en (advance one position),
//        o_pad (current position is on the pad border), o_first (position (0,0)),
//        o_last (terminal position (PH-1,PW-1))
module raster_counter
   import pad_streamer_pkg::*;
#(
   parameter int PW = DEF_PW,
   parameter int PH = DEF_PH
)
(
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_pad,
   output logic o_first,
   output logic o_last
);
   localparam int RW = $clog2(PH);
   localparam int CW = $clog2(PW);
   localparam logic [RW-1:0] LAST_R = RW'(PH - 1);
   localparam logic [CW-1:0] LAST_C = CW'(PW - 1);
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic w_eol;
   assign w_eol   = r_col == LAST_C;
   assign o_last  = w_eol && r_row == LAST_R;
   assign o_first = r_row == '0 && r_col == '0;
   assign o_pad   = r_row == '0 || r_row == LAST_R || r_col == '0 || w_eol;
   // the terminal position wraps back to (0,0) so a frame can follow immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr || (i_en && o_last)) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_en) begin
         r_col <= w_eol ? '0 : r_col + CW'(1);
         r_row <= w_eol ? r_row + RW'(1) : r_row;
      end
   end
endmodule

// File: rtl/pad_streamer.sv
// pad_streamer: streams an image from memory as a zero-padded raster frame
// ports: clk, rst (async, active-high), start (frame request, sampled in IDLE),
//        mem_re/mem_addr/mem_rdata (image memory, read data one cycle after mem_re),
//        pix_out/pix_valid/frame_first (padded raster stream), busy (not IDLE), done (frame end pulse)
module pad_streamer
   import pad_streamer_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          mem_re,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] pix_out,
   output logic          pix_valid,
   output logic          frame_first,
   output logic          busy,
   output logic          done
);
   localparam int PW = IMG_W + 2;
   localparam int PH = IMG_H + 2;
   logic [1:0]    r_state;
   logic [AW-1:0] r_addr;
   logic          r_valid, r_pad, r_first, r_done;
   logic          w_stream, w_go, w_pad, w_first, w_last;
   assign w_stream = r_state == S_STREAM;
   assign w_go     = r_state == S_IDLE && start;
   raster_counter #(.PW(PW), .PH(PH)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_go),
      .i_en    (w_stream),
      .o_pad   (w_pad),
      .o_first (w_first),
      .o_last  (w_last)
   );
   // stage 0 issues one position per cycle; stage 1 lines up with the memory read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_pad   <= 1'b0;
         r_first <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_go ? S_STREAM : w_stream ? (w_last ? S_FLUSH : S_STREAM) : S_IDLE;
         r_addr  <= w_go ? '0 : mem_re ? r_addr + AW'(1) : r_addr;
         r_valid <= w_stream;
         r_pad   <= w_pad;
         r_first <= w_stream && w_first;
         r_done  <= r_state == S_FLUSH;
      end
   end
   assign mem_re      = w_stream && !w_pad;
   assign mem_addr    = r_addr;
   assign pix_out     = (r_valid && !r_pad) ? mem_rdata : '0;
   assign pix_valid   = r_valid;
   assign frame_first = r_first;
   assign busy        = r_state != S_IDLE;
   assign done        = r_done;
endmodule

// File: tb/tb_pad_streamer.sv
// tb_pad_streamer: randomized self-checking bench for pad_streamer (4x3 and default 224x224 instances)
module tb_pad_streamer;
   localparam int SW  = 4;
   localparam int SH  = 3;
   localparam int SPW = SW + 2;
   localparam int SNP = SPW * (SH + 2);
   localparam int BW  = 224;
   localparam int BPW = BW + 2;
   localparam int BNP = BPW * BPW;
   logic clk = 1'b0;
   logic rst;
   logic s_start, s_re, s_valid, s_first, s_busy, s_done;
   logic [15:0] s_addr;
   logic [8:0] s_rdata, s_pix;
   logic b_start, b_re, b_valid, b_first, b_busy, b_done;
   logic [15:0] b_addr;
   logic [8:0] b_rdata, b_pix;
   logic [8:0] s_mem [SW*SH];
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   pad_streamer #(.IMG_W(SW), .IMG_H(SH)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .mem_re(s_re), .mem_addr(s_addr), .mem_rdata(s_rdata),
      .pix_out(s_pix), .pix_valid(s_valid), .frame_first(s_first), .busy(s_busy), .done(s_done)
   );
   pad_streamer u_big (
      .clk(clk), .rst(rst), .start(b_start), .mem_re(b_re), .mem_addr(b_addr), .mem_rdata(b_rdata),
      .pix_out(b_pix), .pix_valid(b_valid), .frame_first(b_first), .busy(b_busy), .done(b_done)
   );
   // memories answer one cycle after a read; otherwise they return noise so pad gating is exercised
   always @(posedge clk) begin
      s_rdata <= (s_re && s_addr < 16'(SW*SH)) ? s_mem[s_addr] : 9'($urandom);
      b_rdata <= b_re ? b_addr[8:0] : 9'($urandom);
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic bit s_interior(input int k);
      int r, c;
      r = k / SPW;
      c = k % SPW;
      return r != 0 && r != SH + 1 && c != 0 && c != SPW - 1;
   endfunction
   function automatic logic [8:0] s_exp_pix(input int k);
      int r, c;
      r = k / SPW;
      c = k % SPW;
      return s_interior(k) ? s_mem[(r - 1) * SW + (c - 1)] : 9'd0;
   endfunction
   task automatic fill_random;
      for (int i = 0; i < SW*SH; i++) s_mem[i] = 9'($urandom_range(0, 511));
   endtask
   // starts a frame in the current cycle and follows it to its done cycle
   task automatic run_frame(input string tag, input bit keep, input int poke);
      int rd;
      rd = 0;
      s_start = 1'b1;
      checks++;
      if (s_busy !== 1'b0) begin errors++; $display("FAIL %s idle_busy got=%0b want=0", tag, s_busy); end
      tick();
      for (int j = 1; j <= SNP + 1; j++) begin
         if (j == 1 && !keep) s_start = 1'b0;
         if (poke > 0 && j == poke) s_start = 1'b1;
         if (poke > 0 && j == poke + 1) s_start = 1'b0;
         checks++;
         if (s_busy !== 1'b1 || s_done !== 1'b0) begin
            errors++; $display("FAIL %s busy_done j=%0d got busy=%0b done=%0b want busy=1 done=0", tag, j, s_busy, s_done);
         end
         if (j <= SNP) begin
            checks++;
            if (s_re !== s_interior(j - 1)) begin
               errors++; $display("FAIL %s mem_re pos=%0d got=%0b want=%0b", tag, j - 1, s_re, s_interior(j - 1));
            end
            if (s_interior(j - 1)) begin
               checks++;
               if (s_addr !== 16'(rd)) begin errors++; $display("FAIL %s mem_addr got=%0d want=%0d", tag, s_addr, rd); end
               rd++;
            end
         end else begin
            checks++;
            if (s_re !== 1'b0) begin errors++; $display("FAIL %s mem_re_tail got=%0b want=0", tag, s_re); end
         end
         if (j == 1) begin
            checks++;
            if (s_valid !== 1'b0 || s_pix !== 9'd0 || s_first !== 1'b0) begin
               errors++; $display("FAIL %s lead got valid=%0b pix=%0d first=%0b want 0/0/0", tag, s_valid, s_pix, s_first);
            end
         end else begin
            checks++;
            if (s_valid !== 1'b1 || s_pix !== s_exp_pix(j - 2) || s_first !== (j == 2)) begin
               errors++; $display("FAIL %s pix k=%0d got valid=%0b pix=%0d first=%0b want 1/%0d/%0b",
                                  tag, j - 2, s_valid, s_pix, s_first, s_exp_pix(j - 2), j == 2);
            end
         end
         tick();
      end
      checks++;
      if (s_done !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0 || s_pix !== 9'd0 || s_first !== 1'b0) begin
         errors++; $display("FAIL %s end got done=%0b busy=%0b valid=%0b pix=%0d want 1/0/0/0", tag, s_done, s_busy, s_valid, s_pix);
      end
      checks++;
      if (rd != SW*SH) begin errors++; $display("FAIL %s read_count got=%0d want=%0d", tag, rd, SW*SH); end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      s_start = 1'b0;
      b_start = 1'b0;
      tick();
      tick();
      checks++;
      if ({s_re, s_addr, s_pix, s_valid, s_first, s_busy, s_done} !== '0) begin
         errors++; $display("FAIL reset_small got re=%0b addr=%0d pix=%0d v=%0b f=%0b busy=%0b done=%0b want all 0",
                            s_re, s_addr, s_pix, s_valid, s_first, s_busy, s_done);
      end
      checks++;
      if ({b_re, b_addr, b_pix, b_valid, b_first, b_busy, b_done} !== '0) begin
         errors++; $display("FAIL reset_big got re=%0b addr=%0d busy=%0b done=%0b want all 0", b_re, b_addr, b_busy, b_done);
      end
      rst = 1'b0;
      repeat (2) tick();
   endtask
   task automatic test_basic;
      for (int i = 0; i < SW*SH; i++) s_mem[i] = 9'(i + 1);
      run_frame("basic", 1'b0, 0);
      tick();
      checks++;
      if (s_done !== 1'b0) begin errors++; $display("FAIL basic done_width got=%0b want=0", s_done); end
      repeat (3) tick();
   endtask
   task automatic test_start_busy;
      fill_random();
      run_frame("start_busy", 1'b0, 10);
      tick();
      checks++;
      if (s_done !== 1'b0 || s_busy !== 1'b0) begin
         errors++; $display("FAIL start_busy retrigger got done=%0b busy=%0b want 0/0", s_done, s_busy);
      end
      repeat (3) tick();
   endtask
   task automatic test_reset_mid_frame;
      bit bad;
      fill_random();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      repeat (15) tick();
      checks++;
      if (s_valid !== 1'b1 || s_pix !== s_exp_pix(14)) begin
         errors++; $display("FAIL midrst pre got valid=%0b pix=%0d want 1/%0d", s_valid, s_pix, s_exp_pix(14));
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({s_re, s_addr, s_pix, s_valid, s_first, s_busy, s_done} !== '0) begin
         errors++; $display("FAIL midrst outputs got re=%0b addr=%0d pix=%0d v=%0b f=%0b busy=%0b done=%0b want all 0",
                            s_re, s_addr, s_pix, s_valid, s_first, s_busy, s_done);
      end
      tick();
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s_done !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL midrst quiet got activity after reset want none"); end
      fill_random();
      run_frame("after_rst", 1'b0, 0);
      repeat (3) tick();
   endtask
   task automatic test_back_to_back;
      fill_random();
      run_frame("b2b_first", 1'b1, 0);
      run_frame("b2b_second", 1'b0, 0);
      tick();
      checks++;
      if (s_busy !== 1'b0 || s_done !== 1'b0) begin
         errors++; $display("FAIL b2b stop got busy=%0b done=%0b want 0/0", s_busy, s_done);
      end
      repeat (3) tick();
   endtask
   task automatic test_default_size;
      int n, reads, dones, last_addr, r, c;
      logic [8:0] exp;
      n = 0;
      reads = 0;
      dones = 0;
      last_addr = -1;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int j = 1; j <= BNP + 3; j++) begin
         if (b_re) begin
            checks++;
            if (b_addr !== 16'(reads)) begin errors++; $display("FAIL big addr got=%0d want=%0d", b_addr, reads); end
            reads++;
            last_addr = int'(b_addr);
         end
         if (b_valid) begin
            r = n / BPW;
            c = n % BPW;
            exp = (r == 0 || r == BPW - 1 || c == 0 || c == BPW - 1) ? 9'd0 : 9'((r - 1) * BW + (c - 1));
            checks++;
            if (j != n + 2 || b_pix !== exp || b_first !== (n == 0)) begin
               errors++; $display("FAIL big pix k=%0d j=%0d got pix=%0d first=%0b want %0d/%0b", n, j, b_pix, b_first, exp, n == 0);
            end
            n++;
         end
         if (b_done) begin
            dones++;
            checks++;
            if (j != BNP + 2) begin errors++; $display("FAIL big done_time got j=%0d want %0d", j, BNP + 2); end
         end
         tick();
      end
      checks++;
      if (n != BNP) begin errors++; $display("FAIL big valid_count got=%0d want=%0d", n, BNP); end
      checks++;
      if (reads != BW*BW || last_addr != 50175) begin
         errors++; $display("FAIL big reads got count=%0d last=%0d want %0d/50175", reads, last_addr, BW*BW);
      end
      checks++;
      if (dones != 1 || b_busy !== 1'b0) begin errors++; $display("FAIL big done_count got=%0d busy=%0b want 1/0", dones, b_busy); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_start_busy();
      test_reset_mid_frame();
      test_back_to_back();
      test_default_size();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
